// File: rtl/db_arbiter_pkg.sv
// db_arbiter_pkg: shared encodings for the two-master data-bus arbiter.
// Used by db_arbiter and, when DB_ARB_TIMEOUT_EN is defined, db_arb_timeout.
package db_arbiter_pkg;

  // Arbiter state width and encodings. The OWN encodings are one-hot per
  // master, so the state register doubles as the grant vector.
  localparam int DB_ARB_STATE_W = 2;
  localparam logic [DB_ARB_STATE_W-1:0] DB_ARB_IDLE = 2'b00;
  localparam logic [DB_ARB_STATE_W-1:0] DB_ARB_OWN0 = 2'b01;
  localparam logic [DB_ARB_STATE_W-1:0] DB_ARB_OWN1 = 2'b10;

  // Width of a master identifier (two masters).
  localparam int DB_ARB_ID_W = 1;

  // A master is requesting whenever either strobe is high.
  function automatic logic db_req(input logic re, input logic we);
    return re | we;
  endfunction

  // Ownership state for a given master id.
  function automatic logic [DB_ARB_STATE_W-1:0] db_own_state(input logic [DB_ARB_ID_W-1:0] id);
    return (id == 1'b1) ? DB_ARB_OWN1 : DB_ARB_OWN0;
  endfunction

endpackage

// File: rtl/db_arb_timeout.sv
// db_arb_timeout: wait-cycle counter for a granted transaction.
// Only instantiated when DB_ARB_TIMEOUT_EN is defined. The counter holds the
// number of completed waiting cycles; the cycle that would be the
// TIMEOUT_CYCLES-th wait without db_ready is flagged as the timeout cycle.
module db_arb_timeout
  import db_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic res,
  input  logic i_start,
  input  logic i_own,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Timeout fires in the waiting cycle that reaches the limit.
  assign o_timeout = i_own && !i_ready && (r_cnt == LIMIT);

  // Clear on entry to an OWN state, count each OWN cycle without db_ready.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_own && !i_ready && !o_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/db_arbiter.sv
// db_arbiter: two-master arbiter for the external db_* bus.
// Grants whole transactions, released on db_ready, round-robin on ties.
// Optional feature: define DB_ARB_TIMEOUT_EN to add m0_err/m1_err and a
// per-transaction wait timeout (db_arb_timeout).
module db_arbiter
  import db_arbiter_pkg::*;
#(
  parameter string TAG            = "DbArbiter",
  parameter int    TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic        m0_re,
  input  logic        m0_we,
  input  logic        m0_io,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dataOut,
  output logic [31:0] m0_dataIn,
  output logic        m0_ready,
  input  logic        m1_re,
  input  logic        m1_we,
  input  logic        m1_io,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dataOut,
  output logic [31:0] m1_dataIn,
  output logic        m1_ready,
`ifdef DB_ARB_TIMEOUT_EN
  output logic        m0_err,
  output logic        m1_err,
`endif
  output logic        db_re,
  output logic        db_we,
  output logic        db_io,
  output logic [31:0] db_addr,
  output logic [31:0] db_dataOut,
  input  logic [31:0] db_dataIn,
  input  logic        db_ready,
  output logic [1:0]  grant,
  output logic        busy
);

  logic [DB_ARB_STATE_W-1:0] r_state;
  logic [DB_ARB_STATE_W-1:0] w_state_next;
  logic [DB_ARB_ID_W-1:0]    r_last_grant;
  logic [DB_ARB_ID_W-1:0]    w_last_next;
  logic                      w_req0;
  logic                      w_req1;
  logic                      w_busy;
  logic                      w_timeout;
  logic                      w_done;

  assign w_req0 = db_req(m0_re, m0_we);
  assign w_req1 = db_req(m1_re, m1_we);
  assign w_busy = (r_state != DB_ARB_IDLE);
  // A transaction completes on db_ready or, when enabled, on timeout.
  assign w_done = db_ready | w_timeout;

`ifdef DB_ARB_TIMEOUT_EN
  logic w_own_entry;
  // Any edge that lands in a different OWN state starts a fresh wait count.
  assign w_own_entry = (w_state_next != DB_ARB_IDLE) && (w_state_next != r_state);

  db_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .res      (res),
    .i_start  (w_own_entry),
    .i_own    (w_busy),
    .i_ready  (db_ready),
    .o_timeout(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and round-robin pointer: ties go to the master not granted last.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last_grant;
    case (r_state)
      DB_ARB_IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_next = db_own_state(~r_last_grant);
          w_last_next  = ~r_last_grant;
        end else if (w_req0) begin
          w_state_next = DB_ARB_OWN0;
          w_last_next  = 1'b0;
        end else if (w_req1) begin
          w_state_next = DB_ARB_OWN1;
          w_last_next  = 1'b1;
        end
      end
      DB_ARB_OWN0: begin
        // Owner's own request is ignored in its completion cycle.
        if (w_done) begin
          if (w_req1) begin
            w_state_next = DB_ARB_OWN1;
            w_last_next  = 1'b1;
          end else begin
            w_state_next = DB_ARB_IDLE;
          end
        end else if (!w_req0) begin
          w_state_next = DB_ARB_IDLE;
        end
      end
      DB_ARB_OWN1: begin
        if (w_done) begin
          if (w_req0) begin
            w_state_next = DB_ARB_OWN0;
            w_last_next  = 1'b0;
          end else begin
            w_state_next = DB_ARB_IDLE;
          end
        end else if (!w_req1) begin
          w_state_next = DB_ARB_IDLE;
        end
      end
      default: begin
        w_state_next = DB_ARB_IDLE;
      end
    endcase
  end

  // State and round-robin pointer; reset leaves master 0 winning the first tie.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state      <= DB_ARB_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_next;
    end
  end

  // Combinational bus mux: owner drives db_*, only the owner sees ready/data.
  always_comb begin
    db_re      = 1'b0;
    db_we      = 1'b0;
    db_io      = 1'b0;
    db_addr    = 32'h0;
    db_dataOut = 32'h0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_dataIn  = 32'h0;
    m1_dataIn  = 32'h0;
`ifdef DB_ARB_TIMEOUT_EN
    m0_err     = 1'b0;
    m1_err     = 1'b0;
`endif
    case (r_state)
      DB_ARB_OWN0: begin
        db_re      = m0_re;
        db_we      = m0_we;
        db_io      = m0_io;
        db_addr    = m0_addr;
        db_dataOut = m0_dataOut;
        m0_ready   = w_done;
        m0_dataIn  = w_timeout ? 32'h0 : db_dataIn;
`ifdef DB_ARB_TIMEOUT_EN
        m0_err     = w_timeout;
`endif
      end
      DB_ARB_OWN1: begin
        db_re      = m1_re;
        db_we      = m1_we;
        db_io      = m1_io;
        db_addr    = m1_addr;
        db_dataOut = m1_dataOut;
        m1_ready   = w_done;
        m1_dataIn  = w_timeout ? 32'h0 : db_dataIn;
`ifdef DB_ARB_TIMEOUT_EN
        m1_err     = w_timeout;
`endif
      end
      default: begin
      end
    endcase
  end

  assign grant = r_state;
  assign busy  = w_busy;

  // Elaboration-time sanity check on the timeout limit.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("%s: TIMEOUT_CYCLES must be at least 1", TAG);
  end

  // Simulation-only warning: re and we together is a master protocol violation.
  always @(posedge clk) begin
    if (res && ((m0_re && m0_we) || (m1_re && m1_we))) begin
      $warning("%s: re&we", TAG);
    end
  end

endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Two-master arbiter for the external data bus (db_*) that leaves the CPU core.
- Master 0 is the CPU cache/MMU path; master 1 is a second bus master (DMA / display fetch).
- Grants whole transactions, released on db_ready, with round-robin priority on contention.
- Sits between the masters and the memory/IO bus; the downstream slave sees one ordinary db_* master.

Parameters:
TAG, "DbArbiter", prefix for simulation $display diagnostics
TIMEOUT_CYCLES, 255, max cycles a granted transaction waits for db_ready (used only with DB_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
res  input  1  reset, asynchronous, active-low
m0_re  input  1  master 0 read request
m0_we  input  1  master 0 write request
m0_io  input  1  master 0 IO-space access
m0_addr  input  32  master 0 address
m0_dataOut  input  32  master 0 write data
m0_dataIn  output  32  read data to master 0
m0_ready  output  1  master 0 transaction complete
m1_re, m1_we, m1_io, m1_addr, m1_dataOut, m1_dataIn, m1_ready  same as m0_* for master 1
db_re  output  1  bus read strobe
db_we  output  1  bus write strobe
db_io  output  1  bus IO-space flag
db_addr  output  32  bus address
db_dataOut  output  32  bus write data
db_dataIn  input  32  bus read data
db_ready  input  1  bus transaction complete
grant  output  2  one-hot owner: bit i = master i
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset res is asynchronous, active-low.
- Reset (res=0, immediate):
  - state=IDLE; lastGrant=1, so master 0 wins the first tie.
  - All db_* outputs 0; m*_ready=0; m*_dataIn=0; grant=0; busy=0.
  - A reset mid-transaction drops db_re/db_we at once; there is no completion.
- Request: req_i = m_i_re | m_i_we. A master holds re/we/io/addr/dataOut stable until it sees its own ready.
- States IDLE, OWN0, OWN1 (encodings in DataBus.vh).
- IDLE:
  - Only req_i → OWNi at the next edge.
  - Both → OWN(~lastGrant).
  - On grant, lastGrant := i.
- OWNi:
  - db_* outputs = master i signals, combinational mux.
  - m_i_ready = db_ready, combinational.
  - m_i_dataIn = db_dataIn.
  - The non-owner sees ready=0 and dataIn=0.
- OWNi exit:
  - On db_ready, if req_other → OWNother at that edge (lastGrant := other); else → IDLE.
  - The owner's request in its completion cycle is never counted as a new request.
  - The owner's next request competes in IDLE, or waits behind a handoff.
- Abort: in OWNi with req_i=0 and db_ready=0 → IDLE next edge. Downstream sees re/we low; no ready is returned.
- Latency: a request sampled at edge N puts the strobe on db_* in cycle N+1; minimum transaction is 2 cycles.
- In IDLE all db_* outputs are 0.
- m_i_re & m_i_we both high is forwarded unchanged and is a protocol violation; simulation $display "<TAG>: re&we" fires.
- Fairness: under continuous contention grants alternate 0,1,0,1 with no IDLE bubble between them.

Optional Feature:
- Macro: DB_ARB_TIMEOUT_EN.
- Defined:
  - Adds outputs m0_err, m1_err (1 bit each).
  - Adds a counter of width clog2(TIMEOUT_CYCLES+1), cleared on entry to any OWN state and incremented each OWN cycle without db_ready.
  - When the counter reaches TIMEOUT_CYCLES: m_i_ready=1, m_i_err=1, m_i_dataIn=32'h0 for that one cycle, then normal exit rules apply and db_re/db_we drop.
  - A timed-out transaction does not update lastGrant beyond its original grant.
  - err is 0 on reset and 0 in all other cycles.
- Undefined: no counter and no err ports; OWN waits indefinitely for db_ready.

Decomposition:
- DataBus.vh holds:
  - the `MEM_ACCESS encoding;
  - new defines for arbiter state width and encodings (DB_ARB_IDLE, DB_ARB_OWN0, DB_ARB_OWN1);
  - the master-ID width.
- One sub-module, db_arb_timeout: the counter and compare, instantiated only under DB_ARB_TIMEOUT_EN.
- Mux and FSM stay in db_arbiter.

Test Plan:
- Reset: res=0 with m0_re=1 → db_re=0, grant=0, busy=0. Release res; m0_re=1, addr=0x100 → db_re=1, db_addr=0x100 next cycle, grant=01. Slave ready after 3 cycles with dataIn=0x12345678 → m0_ready=1, m0_dataIn=0x12345678, then IDLE.
- Simultaneous first request: m0_re and m1_we both 1 after reset → master 0 granted first. On db_ready, direct handoff to master 1 next cycle: db_we=1, db_addr=m1_addr, no IDLE cycle.
- Contention: both masters requesting continuously for 6 transactions, each 2-cycle ready → grant sequence 01,10,01,10,01,10. m1_ready never asserts while grant=01.
- Abort: master 1 granted, drops m1_re after 2 cycles with db_ready=0 → IDLE next edge; db_re=0; m1_ready never pulses.
- Mid-transaction reset: res=0 asynchronously during OWN0 → db_re and grant go 0 in the same cycle without waiting for clk. The next grant after release goes to master 0 on a tie.
- Timeout (DB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): m0_re, db_ready held 0 → m0_ready=1, m0_err=1, m0_dataIn=0 in the 4th OWN0 cycle; then db_re=0. Without the macro the same stimulus stays in OWN0 for 100+ cycles.
